poly1305_feeder: RTL and testbench

- Hardware host-side driver for the poly1305 core. It issues the core's ld/first/fb block protocol, which is otherwise driven only by the testbench.
- Accepts a 256-bit one-time key plus a byte-serial message.
- Packs bytes into little-endian 128-bit blocks, applies final-block padding, and sequences blocks into the core with ld/rdy.
- Captures the core's p output as the tag once the last block completes. Sits between a byte-stream source (DMA/UART front end) and poly1305.

---
 rtl/poly1305_feeder.sv | 173 +++++++++++++++++
 tb/tb_poly1305_feeder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/poly1305_feeder.sv
// Host-side driver for a poly1305 core: packs a byte stream into padded little-endian
// 128-bit blocks, sequences them with ld/first/fb against rdy, and captures the tag.
module poly1305_feeder #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [255:0]     key,
    input  logic [7:0]       din,
    input  logic             din_valid,
    input  logic             din_last,
    output logic             din_ready,
    output logic [127:0]     r,
    output logic [127:0]     s,
    output logic [127:0]     m,
    output logic             fb,
    output logic             ld,
    output logic             first,
    input  logic             rdy,
    input  logic [127:0]     p,
    output logic [127:0]     tag,
    output logic             tag_valid,
    input  logic             tag_ready,
    output logic             busy,
    output logic [LEN_W-1:0] msg_len
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COLLECT = 3'd1;
    localparam logic [2:0] S_ISSUE   = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_TAG     = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [127:0]     r_q, r_d, s_q, s_d, m_q, m_d, tag_q, tag_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             fp_q, fp_d;
    logic             first_q, first_d;
    logic             fb_q, fb_d;
    logic             last_q, last_d;
    logic             armed_q, armed_d;
    logic             tv_q, tv_d;

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        s_d     = s_q;
        m_d     = m_q;
        tag_d   = tag_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        fp_d    = fp_q;
        first_d = first_q;
        fb_d    = fb_q;
        last_d  = last_q;
        armed_d = armed_q;
        tv_d    = tv_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    r_d     = key[127:0];
                    s_d     = key[255:128];
                    m_d     = '0;
                    cnt_d   = '0;
                    len_d   = '0;
                    fp_d    = 1'b1;
                    last_d  = 1'b0;
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (din_valid) begin
                    // Data byte lands at slot c; a final short block also gets 0x01 at slot c+1.
                    for (int i = 0; i < 16; i++) begin
                        if (5'(i) == cnt_q) begin
                            m_d[8*i +: 8] = din;
                        end else if (din_last && (5'(i) == cnt_q + 5'd1)) begin
                            m_d[8*i +: 8] = 8'h01;
                        end
                    end
                    cnt_d = cnt_q + 5'd1;
                    if (len_q != {LEN_W{1'b1}}) begin
                        len_d = len_q + {{(LEN_W-1){1'b0}}, 1'b1};
                    end
                    if (din_last || (cnt_q == 5'd15)) begin
                        last_d  = din_last;
                        first_d = fp_q;
                        fb_d    = (cnt_q == 5'd15);
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (rdy) begin
                    fp_d    = 1'b0;
                    armed_d = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // rdy is ignored on the first WAIT cycle while the core reacts to ld.
                if (!armed_q) begin
                    armed_d = 1'b1;
                end else if (rdy) begin
                    first_d = 1'b0;
                    if (last_q) begin
                        tag_d   = p;
                        tv_d    = 1'b1;
                        state_d = S_TAG;
                    end else begin
                        m_d     = '0;
                        cnt_d   = '0;
                        state_d = S_COLLECT;
                    end
                end
            end
            S_TAG: begin
                if (tag_ready) begin
                    tv_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            s_q     <= '0;
            m_q     <= '0;
            tag_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            fp_q    <= 1'b0;
            first_q <= 1'b0;
            fb_q    <= 1'b0;
            last_q  <= 1'b0;
            armed_q <= 1'b0;
            tv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            s_q     <= s_d;
            m_q     <= m_d;
            tag_q   <= tag_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            fp_q    <= fp_d;
            first_q <= first_d;
            fb_q    <= fb_d;
            last_q  <= last_d;
            armed_q <= armed_d;
            tv_q    <= tv_d;
        end
    end

    assign din_ready = (state_q == S_COLLECT);
    assign ld        = (state_q == S_ISSUE) && rdy;
    assign busy      = (state_q != S_IDLE);
    assign r         = r_q;
    assign s         = s_q;
    assign m         = m_q;
    assign fb        = fb_q;
    assign first     = first_q;
    assign tag       = tag_q;
    assign tag_valid = tv_q;
    assign msg_len   = len_q;

endmodule

// File: tb/tb_poly1305_feeder.sv
// Directed bench for poly1305_feeder with a behavioural poly1305 core attached.
module tb_poly1305_feeder;
    localparam int LEN_W = 16;
    localparam int LAT   = 3;
    localparam logic [127:0] R_EXP   = 128'ha806d542fe52447f336d555778bed685;
    localparam logic [127:0] S_EXP   = 128'h1bf54941aff6bf4afdb20dfb8a800301;
    localparam logic [127:0] TAG_EXP = 128'ha927010caf8b2bc2c6365130c11d06a8;

    logic clk = 1'b0;
    logic reset, start, din_valid, din_last, din_ready;
    logic fb, ld, first, rdy, tag_valid, tag_ready, busy;
    logic [255:0] key;
    logic [7:0]   din;
    logic [127:0] r, s, m, p, tag;
    logic [LEN_W-1:0] msg_len;

    always #5 clk = ~clk;

    poly1305_feeder #(.LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .start(start), .key(key),
        .din(din), .din_valid(din_valid), .din_last(din_last), .din_ready(din_ready),
        .r(r), .s(s), .m(m), .fb(fb), .ld(ld), .first(first), .rdy(rdy), .p(p),
        .tag(tag), .tag_valid(tag_valid), .tag_ready(tag_ready),
        .busy(busy), .msg_len(msg_len)
    );

    // Behavioural core: acc = (acc + block) * clamp(r) mod 2^130-5, p = acc + s.
    function automatic logic [129:0] poly_step(input logic [129:0] acc, input logic [127:0] mm,
                                               input logic fbb, input logic [127:0] rr);
        logic [259:0] a, rc, t, mask, pr;
        mask = (260'd1 << 130) - 260'd1;
        pr   = (260'd1 << 130) - 260'd5;
        a    = 260'(acc) + 260'(mm) + (fbb ? (260'd1 << 128) : 260'd0);
        rc   = 260'(rr & 128'h0ffffffc0ffffffc0ffffffc0fffffff);
        t    = a * rc;
        for (int i = 0; i < 3; i++) t = (t & mask) + 260'd5 * (t >> 130);
        if (t >= pr) t = t - pr;
        return t[129:0];
    endfunction

    logic rdy_q, core_block;
    logic [129:0] acc_q, acc_pend;
    logic [127:0] s_pend;
    int lat_cnt;
    int n_ld = 0;
    logic [127:0] ld_m [0:63];
    logic ld_fb [0:63];
    logic ld_first [0:63];

    assign rdy = rdy_q & ~core_block;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_q   <= 1'b1;
            lat_cnt <= 0;
            acc_q   <= '0;
            p       <= '0;
        end else if (ld) begin
            rdy_q    <= 1'b0;
            lat_cnt  <= LAT;
            acc_pend <= poly_step(first ? 130'd0 : acc_q, m, fb, r);
            s_pend   <= s;
            if (n_ld < 64) begin
                ld_m[n_ld]     <= m;
                ld_fb[n_ld]    <= fb;
                ld_first[n_ld] <= first;
            end
            n_ld <= n_ld + 1;
        end else if (lat_cnt > 0) begin
            lat_cnt <= lat_cnt - 1;
            if (lat_cnt == 1) begin
                rdy_q <= 1'b1;
                acc_q <= acc_pend;
                p     <= acc_pend[127:0] + s_pend;
            end
        end
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic check_eq(input string name, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    logic [7:0]   msg [0:63];
    logic [255:0] key_val;
    logic [127:0] ref_m [0:2];
    int base;

    task automatic do_reset();
        din_valid = 1'b0;
        #1 reset = 1'b0;
        #1;
        check_eq("rst_data", {r, s, m, tag}, 512'd0);
        check_eq("rst_ctl", {ld, first, fb, din_ready, tag_valid, busy, msg_len}, 512'd0);
        #1 reset = 1'b1;
    endtask

    task automatic run_msg(input int len, input bit throttle, input int tag_hold,
                           input int stall, input bit poke, input int reset_at, output bit aborted);
        int i;
        int cyc;
        bit bad;
        logic [127:0] t0;
        aborted = 1'b0;
        base = n_ld;
        @(negedge clk); key = key_val; start = 1'b1;
        @(negedge clk); start = 1'b0;
        if (stall > 0) core_block = 1'b1;
        i = 0; cyc = 0;
        while (i < len && cyc < 4000) begin
            @(negedge clk); cyc++;
            din_valid = 1'b0; din_last = 1'b0;
            if (reset_at > 0 && n_ld - base == reset_at) begin
                do_reset();
                aborted = 1'b1;
                return;
            end
            if (poke) begin start = 1'b1; key = ~key_val; end
            if (din_ready && (!throttle || cyc % 2 == 0)) begin
                din = msg[i]; din_valid = 1'b1; din_last = (i == len - 1); i++;
            end
        end
        @(negedge clk); din_valid = 1'b0; din_last = 1'b0; start = 1'b0; key = key_val;
        check_eq("bytes_fed", i, len);
        if (stall > 0) begin
            repeat (stall) @(negedge clk);
            check_eq("issue_gated", {busy, 32'(n_ld - base)}, {1'b1, 32'd0});
            core_block = 1'b0;
        end
        cyc = 0;
        while (!tag_valid && cyc < 300) begin @(negedge clk); cyc++; end
        check_eq("tag_valid_up", tag_valid, 1'b1);
        bad = 1'b0; t0 = tag;
        repeat (tag_hold) begin
            @(negedge clk); start = 1'b1; din_valid = 1'b1;
            if (!tag_valid || tag !== t0 || din_ready || !busy) bad = 1'b1;
        end
        start = 1'b0; din_valid = 1'b0;
        if (tag_hold > 0) check_eq("tag_hold", bad, 1'b0);
        tag_ready = 1'b1;
        @(negedge clk); tag_ready = 1'b0;
        check_eq("back_idle", {busy, tag_valid}, 2'b00);
        $display("msg len=%0d blocks=%0d msg_len=%0d tag=%h", len, n_ld - base, msg_len, tag);
    endtask

    task automatic load_rfc();
        string str;
        str = "Cryptographic Forum Research Group";
        for (int k = 0; k < str.len(); k++) msg[k] = str[k];
    endtask

    initial begin
        logic [7:0] kb [0:31];
        logic [127:0] exp_m2;
        logic [LEN_W-1:0] len_save;
        logic [127:0] m_save;
        bit ab;
        kb = '{8'h85, 8'hd6, 8'hbe, 8'h78, 8'h57, 8'h55, 8'h6d, 8'h33,
               8'h7f, 8'h44, 8'h52, 8'hfe, 8'h42, 8'hd5, 8'h06, 8'ha8,
               8'h01, 8'h03, 8'h80, 8'h8a, 8'hfb, 8'h0d, 8'hb2, 8'hfd,
               8'h4a, 8'hbf, 8'hf6, 8'haf, 8'h41, 8'h49, 8'hf5, 8'h1b};
        for (int k = 0; k < 32; k++) key_val[8*k +: 8] = kb[k];
        start = 1'b0; din_valid = 1'b0; din_last = 1'b0; din = 8'h00;
        tag_ready = 1'b0; core_block = 1'b0; key = '0;
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("reset_data", {r, s, m, tag}, 512'd0);
        check_eq("reset_ctl", {ld, first, fb, din_ready, tag_valid, busy, msg_len}, 512'd0);
        reset = 1'b1;

        // RFC 8439 vector
        load_rfc();
        run_msg(34, 1'b0, 0, 0, 1'b0, 0, ab);
        check_eq("rfc_r", r, R_EXP);
        check_eq("rfc_s", s, S_EXP);
        check_eq("rfc_nld", n_ld - base, 3);
        check_eq("rfc_first", {ld_first[base], ld_first[base+1], ld_first[base+2]}, 3'b100);
        check_eq("rfc_fb", {ld_fb[base], ld_fb[base+1], ld_fb[base+2]}, 3'b110);
        check_eq("rfc_m3", ld_m[base+2], 128'h017075);
        check_eq("rfc_tag", tag, TAG_EXP);
        check_eq("rfc_len", msg_len, 34);
        for (int k = 0; k < 3; k++) ref_m[k] = ld_m[base+k];

        // Same message, din_valid every other cycle, tag held off 10 cycles
        run_msg(34, 1'b1, 10, 0, 1'b0, 0, ab);
        check_eq("thr_m", {ld_m[base], ld_m[base+1], ld_m[base+2]}, {ref_m[0], ref_m[1], ref_m[2]});
        check_eq("thr_tag", tag, TAG_EXP);

        // Exactly 32 bytes, start poked while collecting
        for (int k = 0; k < 32; k++) msg[k] = 8'(k);
        for (int k = 0; k < 16; k++) exp_m2[8*k +: 8] = 8'(16 + k);
        run_msg(32, 1'b0, 0, 0, 1'b1, 0, ab);
        check_eq("b32_nld", n_ld - base, 2);
        check_eq("b32_fb", {ld_fb[base], ld_fb[base+1]}, 2'b11);
        check_eq("b32_m2", ld_m[base+1], exp_m2);
        check_eq("b32_tag", tag, p);
        check_eq("b32_len", msg_len, 32);
        check_eq("b32_r_kept", r, R_EXP);

        // One byte, with the core holding rdy low while ISSUE waits
        msg[0] = 8'hAB;
        run_msg(1, 1'b0, 0, 5, 1'b0, 0, ab);
        check_eq("b1_nld", n_ld - base, 1);
        check_eq("b1_ld", {ld_first[base], ld_fb[base]}, 2'b10);
        check_eq("b1_m", ld_m[base], 128'h01AB);
        check_eq("b1_len", msg_len, 1);

        // Stray din_valid/din_last in IDLE
        len_save = msg_len; m_save = m;
        repeat (5) begin
            @(negedge clk); din_valid = 1'b1; din_last = 1'b1; din = 8'h5A;
        end
        @(negedge clk); din_valid = 1'b0; din_last = 1'b0;
        check_eq("idle_ignore", {busy, din_ready, msg_len, m}, {1'b0, 1'b0, len_save, m_save});

        // Reset during WAIT of block 2, then a clean rerun
        load_rfc();
        run_msg(34, 1'b0, 0, 0, 1'b0, 2, ab);
        check_eq("rst_aborted", ab, 1'b1);
        run_msg(34, 1'b0, 0, 0, 1'b0, 0, ab);
        check_eq("rst_rerun_tag", tag, TAG_EXP);
        check_eq("rst_rerun_len", msg_len, 34);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
